// File: rtl/wishbone_master_arbiter.sv
// rtl/wishbone_master_arbiter.sv - two-master round-robin Wishbone B3 classic arbiter
// Optional ack watchdog with ABORT state: define WB_ARB_TIMEOUT_EN.
module wishbone_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    output logic [1:0]              grant_o
);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_BITS  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_WIDTH = (CNT_BITS > 8) ? CNT_BITS : 8;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 timeout_hit;
`else
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    state_t state;
    logic   prefer_m1;
    logic   in_grant;
    logic   owner_m1;
    logic   owner_cyc;

    // grant_o is held through ABORT, so it names the owner in every non-idle state
    assign in_grant  = (state == GRANT0) || (state == GRANT1);
    assign owner_m1  = grant_o[1];
    assign owner_cyc = owner_m1 ? m1_cyc_i : m0_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
    assign timeout_hit = in_grant && (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prefer_m1 <= 1'b0;
            grant_o   <= 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef WB_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (m0_cyc_i && !(m1_cyc_i && prefer_m1)) begin
                        state     <= GRANT0;
                        grant_o   <= 2'b01;
                        prefer_m1 <= 1'b1;
                    end else if (m1_cyc_i) begin
                        state     <= GRANT1;
                        grant_o   <= 2'b10;
                        prefer_m1 <= 1'b0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (!owner_cyc) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state <= ABORT;
                    end
                    if (!s_ack_i) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ABORT: begin
                    if (!owner_cyc) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

    // Slave side follows the owner combinationally so a flush drops s_cyc_o in the same cycle
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        m1_err_o = 1'b0;
        if (in_grant) begin
            s_cyc_o = owner_cyc;
            s_stb_o = owner_cyc & (owner_m1 ? m1_stb_i : m0_stb_i);
            s_we_o  = owner_m1 ? m1_we_i  : m0_we_i;
            s_sel_o = owner_m1 ? m1_sel_i : m0_sel_i;
            s_adr_o = owner_m1 ? m1_adr_i : m0_adr_i;
            s_dat_o = owner_m1 ? m1_dat_i : m0_dat_i;
            if (owner_m1) begin
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end else begin
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
`ifdef WB_ARB_TIMEOUT_EN
            if (timeout_hit) begin
                s_cyc_o  = 1'b0;
                s_stb_o  = 1'b0;
                m0_ack_o = 1'b0;
                m1_ack_o = 1'b0;
                m0_err_o = !owner_m1;
                m1_err_o = owner_m1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// tb/tb_wishbone_master_arbiter.sv - directed scoreboard bench for wishbone_master_arbiter
module tb_wishbone_master_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        m1;
        logic [31:0] data;
    } ack_exp_t;

    ack_exp_t   ack_q[$];
    logic [1:0] grant_q[$];
    logic       exp_prefer_m1;
    logic       own;
    int         idle;

    wishbone_master_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Round-robin reference: lone requester wins, otherwise the preferred one
    task automatic req_model(input logic r0, input logic r1, output logic own_m1);
        own_m1 = !(r0 && !(r1 && exp_prefer_m1));
        grant_q.push_back(own_m1 ? 2'b10 : 2'b01);
        exp_prefer_m1 = !own_m1;
    endtask

    task automatic wait_grant(input string tag, output int idle_cnt);
        logic [1:0] e;
        idle_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check({tag, "_not_both"}, 64'(grant_o == 2'b11), 64'd0);
            if (grant_o != 2'b00) break;
            idle_cnt++;
        end
        e = (grant_q.size() != 0) ? grant_q.pop_front() : 2'b11;
        check({tag, "_grant"}, 64'(grant_o), 64'(e));
    endtask

    task automatic wait_ack(input string tag);
        ack_exp_t e;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clock);
            if (m0_ack_o || m1_ack_o) seen = 1'b1;
        end
        check({tag, "_ack_seen"}, 64'(seen), 64'd1);
        if (!seen) return;
        check({tag, "_sb_nonempty"}, 64'(ack_q.size() != 0), 64'd1);
        if (ack_q.size() == 0) return;
        e = ack_q.pop_front();
        check({tag, "_ack_owner"}, 64'({m1_ack_o, m0_ack_o}), 64'(e.m1 ? 2'b10 : 2'b01));
        check({tag, "_ack_data"}, 64'(e.m1 ? m1_dat_o : m0_dat_o), 64'(e.data));
        check({tag, "_other_dat"}, 64'(e.m1 ? m0_dat_o : m1_dat_o), 64'd0);
    endtask

    task automatic finish_owner(input logic own_m1, input logic [31:0] data, input string tag);
        ack_exp_t e;
        tick();
        s_ack_i = 1'b1;
        s_dat_i = data;
        e.m1 = own_m1;
        e.data = data;
        ack_q.push_back(e);
        wait_ack(tag);
        tick();
        s_ack_i = 1'b0;
        s_dat_i = '0;
        if (own_m1) begin
            m1_cyc_i = 1'b0;
            m1_stb_i = 1'b0;
        end else begin
            m0_cyc_i = 1'b0;
            m0_stb_i = 1'b0;
        end
        @(negedge clock);
        check({tag, "_release_s_cyc"}, 64'(s_cyc_o), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i} = '0;
        {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i} = '0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        exp_prefer_m1 = 1'b0;

        @(negedge clock);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        check("rst_s_stb", 64'(s_stb_o), 64'd0);
        check("rst_acks", 64'({m1_ack_o, m0_ack_o}), 64'd0);
        check("rst_errs", 64'({m1_err_o, m0_err_o}), 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // Single m0 read, slave answers two cycles after the request
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100; m0_we_i = 1'b0; m0_sel_i = 4'hF;
        req_model(1'b1, 1'b0, own);
        @(negedge clock);
        check("t1_cycle0_s_cyc", 64'(s_cyc_o), 64'd0);
        wait_grant("t1", idle);
        check("t1_s_cyc", 64'(s_cyc_o), 64'd1);
        check("t1_s_stb", 64'(s_stb_o), 64'd1);
        check("t1_s_adr", 64'(s_adr_o), 64'h100);
        check("t1_s_we", 64'(s_we_o), 64'd0);
        finish_owner(1'b0, 32'hDEADBEEF, "t1");
        tick();
        check("t1_idle_after", 64'(grant_o), 64'd0);

        // Simultaneous requests alternate after a fresh reset
        reset = 1'b1;
        exp_prefer_m1 = 1'b0;
        tick();
        reset = 1'b0;
        m0_adr_i = 32'h1000;
        m1_adr_i = 32'h2000;
        for (int r = 0; r < 4; r++) begin
            tick();
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
            m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            req_model(1'b1, 1'b1, own);
            wait_grant("t2", idle);
            if (r > 0) check("t2_idle_gap", 64'(idle), 64'd1);
            check("t2_s_adr", 64'(s_adr_o), own ? 64'h2000 : 64'h1000);
            finish_owner(own, 32'hC0DE0000 + 32'(r), "t2");
        end
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;

        // m1 write held against a competing m0 request, with a strobe gap
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
        m1_adr_i = 32'h200; m1_dat_i = 32'h12345678; m1_sel_i = 4'b1100;
        req_model(1'b0, 1'b1, own);
        wait_grant("t3", idle);
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h300; m0_we_i = 1'b0;
        @(negedge clock);
        check("t3_hold_grant", 64'(grant_o), 64'h2);
        check("t3_s_adr", 64'(s_adr_o), 64'h200);
        check("t3_m0_ack", 64'(m0_ack_o), 64'd0);
        tick();
        m1_stb_i = 1'b0;
        @(negedge clock);
        check("t3_gap_grant", 64'(grant_o), 64'h2);
        check("t3_gap_cyc_stb", 64'({s_cyc_o, s_stb_o}), 64'h2);
        tick();
        m1_stb_i = 1'b1;
        @(negedge clock);
        check("t3_s_stb", 64'(s_stb_o), 64'd1);
        check("t3_s_we", 64'(s_we_o), 64'd1);
        check("t3_s_dat", 64'(s_dat_o), 64'h12345678);
        check("t3_s_sel", 64'(s_sel_o), 64'hC);
        finish_owner(1'b1, 32'h0BADF00D, "t3");
        m1_we_i = 1'b0;
        req_model(1'b1, 1'b0, own);
        wait_grant("t3_m0", idle);
        check("t3_idle_gap", 64'(idle), 64'd1);
        check("t3_m0_adr", 64'(s_adr_o), 64'h300);
        finish_owner(1'b0, 32'hA5A55A5A, "t3_m0");

        // Flush: m0 drops cyc without ack, slave acks late
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h400;
        req_model(1'b1, 1'b0, own);
        wait_grant("t4", idle);
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clock);
        check("t4_flush_cyc_stb", 64'({s_cyc_o, s_stb_o}), 64'd0);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hFFFF0000;
        @(negedge clock);
        check("t4_late_ack", 64'({m1_ack_o, m0_ack_o}), 64'd0);
        check("t4_late_dat", 64'(m0_dat_o), 64'd0);
        check("t4_idle", 64'(grant_o), 64'd0);
        tick();
        s_ack_i = 1'b0; s_dat_i = '0;

        // Ack arriving in the same cycle cyc drops is still delivered
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        req_model(1'b1, 1'b0, own);
        wait_grant("t4b", idle);
        begin
            ack_exp_t e;
            tick();
            s_ack_i = 1'b1; s_dat_i = 32'h600DCAFE;
            m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
            e.m1 = 1'b0;
            e.data = 32'h600DCAFE;
            ack_q.push_back(e);
            wait_ack("t4b");
            check("t4b_s_cyc", 64'(s_cyc_o), 64'd0);
        end
        tick();
        s_ack_i = 1'b0; s_dat_i = '0;

        // Asynchronous reset while m1 owns the bus
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h500;
        req_model(1'b0, 1'b1, own);
        wait_grant("t5", idle);
        check("t5_s_cyc", 64'(s_cyc_o), 64'd1);
        #1;
        s_ack_i = 1'b1; s_dat_i = 32'h13579BDF;
        #1;
        reset = 1'b1;
        exp_prefer_m1 = 1'b0;
        #1;
        check("t5_rst_grant", 64'(grant_o), 64'd0);
        check("t5_rst_cyc_stb_we", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'd0);
        check("t5_rst_s_adr", 64'(s_adr_o), 64'd0);
        check("t5_rst_m1_ack", 64'(m1_ack_o), 64'd0);
        check("t5_rst_m1_dat", 64'(m1_dat_o), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        s_ack_i = 1'b0; s_dat_i = '0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h700;
        req_model(1'b1, 1'b1, own);
        wait_grant("t5_after", idle);
        check("t5_after_adr", 64'(s_adr_o), 64'h700);
        finish_owner(1'b0, 32'h2468ACE0, "t5_m0");
        req_model(1'b0, 1'b1, own);
        wait_grant("t5_m1", idle);
        finish_owner(1'b1, 32'h11223344, "t5_m1");

`ifdef WB_ARB_TIMEOUT_EN
        // Hung slave: err pulse four cycles after the grant, then ABORT
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h800;
        req_model(1'b1, 1'b0, own);
        wait_grant("t6", idle);
        begin
            int k;
            k = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clock);
                if (m0_err_o) begin
                    k = i;
                    break;
                end
            end
            check("t6_err_delay", 64'(k), 64'd4);
            check("t6_err_s_cyc", 64'(s_cyc_o), 64'd0);
            check("t6_err_ack", 64'(m0_ack_o), 64'd0);
        end
        @(negedge clock);
        check("t6_err_single", 64'(m0_err_o), 64'd0);
        check("t6_abort_s_cyc", 64'(s_cyc_o), 64'd0);
        check("t6_abort_grant", 64'(grant_o), 64'h1);
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        @(negedge clock);
        check("t6_idle", 64'(grant_o), 64'd0);
`endif

        check("sb_ack_drained", 64'(ack_q.size()), 64'd0);
        check("sb_grant_drained", 64'(grant_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
